clint_timer: RTL

Parametrised RISC-V core-local interruptor (CLINT) for IOb SoCs with one or more harts. It holds a 64-bit free-running `mtime` advanced by an internal prescaled tick, a 64-bit `mtimecmp` per hart and a 1-bit `msip` per hart. It drives per-hart machine timer and software interrupt pins. It attaches to the native valid/ready peripheral bus with a fixed one-cycle response.

---
 rtl/clint_timer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/clint_timer.sv
// clint_timer: RISC-V core-local interruptor (mtime, per-hart mtimecmp/msip) on the native valid/ready bus.
// Define CLINT_RTC_DIV_EN to advance mtime once every RTC_DIV clocks instead of every clock.

module clint_timer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int N_CORES = 1,
    parameter int RTC_DIV = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic [N_CORES-1:0]    mtip,
    output logic [N_CORES-1:0]    msip
);

    localparam logic [4:0] NCORES_C = 5'(N_CORES);

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    logic [3:0]  w_idx_msip;
    logic [3:0]  w_idx_cmp;
    logic        w_hit_msip;
    logic        w_hit_cmp;
    logic        w_hit_time;
    logic        w_wr;
    logic        w_rd;
    logic        w_tick;
    logic [63:0] w_mtime_nxt;
    logic [31:0] w_cmp_rd;
    logic [31:0] w_msip_rd;
    logic [31:0] w_rdata;
    logic        w_unused;

    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp [N_CORES];
    logic [N_CORES-1:0] r_msip;
    logic [N_CORES-1:0] r_mtip;
    logic               r_ready;
    logic [31:0]        r_rdata;

    // Only address[15:2] takes part in decoding.
    assign w_unused   = ^{address[ADDR_W-1:16], address[1:0]};

    assign w_idx_msip = address[5:2];
    assign w_idx_cmp  = address[6:3];
    assign w_hit_msip = (address[15:6] == 10'd0) && ({1'b0, w_idx_msip} < NCORES_C);
    assign w_hit_cmp  = (address[15:7] == 9'h080) && ({1'b0, w_idx_cmp} < NCORES_C);
    assign w_hit_time = (address[15:3] == 13'h17FF);
    assign w_wr       = valid & (|wstrb);
    assign w_rd       = valid & ~(|wstrb);

`ifdef CLINT_RTC_DIV_EN
    localparam logic [16:0] DIV_LAST = 17'(RTC_DIV - 1);

    logic [16:0] r_presc;

    // Prescale counter 0..RTC_DIV-1, tick on the last count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= 17'd0;
        end else if (r_presc == DIV_LAST) begin
            r_presc <= 17'd0;
        end else begin
            r_presc <= r_presc + 17'd1;
        end
    end

    assign w_tick = (r_presc == DIV_LAST);
`else
    logic [16:0] w_unused_div;

    assign w_unused_div = 17'(RTC_DIV);
    assign w_tick       = 1'b1;
`endif

    // A bus write to either mtime word suppresses the whole 64-bit increment.
    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_wr && w_hit_time) begin
            if (address[2]) begin
                w_mtime_nxt[63:32] = merge_bytes(r_mtime[63:32], wdata, wstrb);
            end else begin
                w_mtime_nxt[31:0]  = merge_bytes(r_mtime[31:0], wdata, wstrb);
            end
        end else if (w_tick) begin
            w_mtime_nxt = r_mtime + 64'd1;
        end else begin
            w_mtime_nxt = r_mtime;
        end
    end

    // Free-running machine time register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime <= 64'd0;
        end else begin
            r_mtime <= w_mtime_nxt;
        end
    end

    // Per-hart compare/software-interrupt registers and registered timer compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CORES; i++) begin
                r_mtimecmp[i] <= {64{1'b1}};
            end
            r_msip <= {N_CORES{1'b0}};
            r_mtip <= {N_CORES{1'b0}};
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (w_wr && w_hit_cmp && (w_idx_cmp == 4'(i))) begin
                    if (address[2]) begin
                        r_mtimecmp[i][63:32] <= merge_bytes(r_mtimecmp[i][63:32], wdata, wstrb);
                    end else begin
                        r_mtimecmp[i][31:0]  <= merge_bytes(r_mtimecmp[i][31:0], wdata, wstrb);
                    end
                end
                if (w_wr && w_hit_msip && (w_idx_msip == 4'(i)) && wstrb[0]) begin
                    r_msip[i] <= wdata[0];
                end
                r_mtip[i] <= (r_mtime >= r_mtimecmp[i]);
            end
        end
    end

    // Read multiplexer; unmapped offsets and absent harts return zero.
    always_comb begin
        w_cmp_rd  = 32'd0;
        w_msip_rd = 32'd0;
        for (int i = 0; i < N_CORES; i++) begin
            w_cmp_rd  = w_cmp_rd | (((w_idx_cmp == 4'(i)) && address[2]) ? r_mtimecmp[i][63:32] : 32'd0)
                                 | (((w_idx_cmp == 4'(i)) && !address[2]) ? r_mtimecmp[i][31:0] : 32'd0);
            w_msip_rd = w_msip_rd | ((w_idx_msip == 4'(i)) ? {31'd0, r_msip[i]} : 32'd0);
        end
        if (w_hit_time) begin
            w_rdata = address[2] ? r_mtime[63:32] : r_mtime[31:0];
        end else if (w_hit_cmp) begin
            w_rdata = w_cmp_rd;
        end else if (w_hit_msip) begin
            w_rdata = w_msip_rd;
        end else begin
            w_rdata = 32'd0;
        end
    end

    // One-cycle bus response; rdata is zero outside read responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= valid;
            r_rdata <= w_rd ? w_rdata : 32'd0;
        end
    end

    assign ready = r_ready;
    assign rdata = r_rdata;
    assign mtip  = r_mtip;
    assign msip  = r_msip;

endmodule
